// File: rtl/std_block_ram_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between NUM_PORTS requesters,
// with optional zero-fill after reset and in-order response routing back to the issuer.
module std_block_ram_arbiter #(
    parameter int NUM_PORTS         = 2,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 10,
    parameter int MASK_WIDTH        = DATA_WIDTH / 8,
    parameter int ENABLE_OUTPUT_REG = 0,
    parameter int CLEAR_ON_RESET    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             i_req_valid,
    output logic [NUM_PORTS-1:0]             o_req_ready,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]  i_req_write_enable,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  i_req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_req_data,
    output logic [NUM_PORTS-1:0]             o_resp_valid,
    output logic [DATA_WIDTH-1:0]            o_resp_data,
    output logic                             o_init_done,
    output logic                             o_ram_enable,
    output logic                             o_ram_enable_output,
    output logic [MASK_WIDTH-1:0]            o_ram_write_enable,
    output logic [ADDR_WIDTH-1:0]            o_ram_addr,
    output logic [DATA_WIDTH-1:0]            o_ram_data_in,
    input  logic [DATA_WIDTH-1:0]            i_ram_data_out
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int LAT   = 1 + ENABLE_OUTPUT_REG;
    localparam logic [PTR_W:0]   NP        = NUM_PORTS[PTR_W:0];
    localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_next_ptr;
    logic [PTR_W-1:0]        w_grant_idx;
    logic                    w_grant_found;
    logic [PTR_W:0]          w_scan;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic [ADDR_WIDTH-1:0]   w_next_init_cnt;
    logic                    r_init_done;
    logic                    r_tag_valid [LAT];
    logic [PTR_W-1:0]        r_tag_port  [LAT];
    logic [NUM_PORTS-1:0]    w_resp_valid;
    logic [NUM_PORTS-1:0]    w_req_ready;
    logic                    w_ram_enable;
    logic [MASK_WIDTH-1:0]   w_ram_write_enable;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0]   w_ram_data_in;

    // Round-robin search: first valid port at or after r_ptr, wrapping at NUM_PORTS.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_scan = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_scan >= NP) begin
                w_scan = w_scan - NP;
            end else begin
                w_scan = w_scan;
            end
            if (!w_grant_found && i_req_valid[w_scan[PTR_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan[PTR_W-1:0];
            end else begin
                w_grant_found = w_grant_found;
            end
        end
    end

    // Next-state logic and RAM pin drive; rst masks every RAM access and handshake.
    always_comb begin
        w_next_state       = r_state;
        w_next_ptr         = r_ptr;
        w_next_init_cnt    = r_init_cnt;
        w_accept           = 1'b0;
        w_req_ready        = '0;
        w_ram_enable       = 1'b0;
        w_ram_write_enable = '0;
        w_ram_addr         = '0;
        w_ram_data_in      = '0;
        case (r_state)
            ST_INIT: begin
                if (!rst) begin
                    w_ram_enable       = 1'b1;
                    w_ram_write_enable = '1;
                    w_ram_addr         = r_init_cnt;
                    w_next_init_cnt    = r_init_cnt + 1'b1;
                    if (r_init_cnt == '1) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_INIT;
                    end
                end else begin
                    w_ram_enable = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_grant_found && !rst) begin
                    w_accept                 = 1'b1;
                    w_req_ready[w_grant_idx] = 1'b1;
                    w_ram_enable             = 1'b1;
                    w_ram_write_enable = i_req_write_enable[w_grant_idx*MASK_WIDTH +: MASK_WIDTH];
                    w_ram_addr         = i_req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    w_ram_data_in      = i_req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
                    if (w_grant_idx == LAST_PORT) begin
                        w_next_ptr = '0;
                    end else begin
                        w_next_ptr = w_grant_idx + 1'b1;
                    end
                end else begin
                    w_accept = 1'b0;
                end
            end
            default: begin
                w_next_state = RESET_STATE;
            end
        endcase
    end

    // State, round-robin pointer, init counter and init_done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RESET_STATE;
            r_ptr       <= '0;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_ptr       <= w_next_ptr;
            r_init_cnt  <= w_next_init_cnt;
            r_init_done <= (w_next_state == ST_RUN);
        end
    end

    // Response tag pipe, one stage per cycle of RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                r_tag_valid[k] <= 1'b0;
                r_tag_port[k]  <= '0;
            end
        end else begin
            r_tag_valid[0] <= w_accept;
            r_tag_port[0]  <= w_grant_idx;
            for (int k = 1; k < LAT; k++) begin
                r_tag_valid[k] <= r_tag_valid[k-1];
                r_tag_port[k]  <= r_tag_port[k-1];
            end
        end
    end

    // A response landing in a reset cycle belongs to a dropped transaction.
    always_comb begin
        w_resp_valid = '0;
        if (r_tag_valid[LAT-1] && !rst) begin
            w_resp_valid[r_tag_port[LAT-1]] = 1'b1;
        end else begin
            w_resp_valid = '0;
        end
    end

    assign o_req_ready         = w_req_ready;
    assign o_resp_valid        = w_resp_valid;
    assign o_resp_data         = i_ram_data_out;
    assign o_init_done         = r_init_done;
    assign o_ram_enable        = w_ram_enable;
    assign o_ram_enable_output = 1'b1;
    assign o_ram_write_enable  = w_ram_write_enable;
    assign o_ram_addr          = w_ram_addr;
    assign o_ram_data_in       = w_ram_data_in;

endmodule

// File: tb/tb_std_block_ram_arbiter.sv
// Bench for std_block_ram_arbiter: two configurations (2 ports / 1-cycle latency, and
// 3 ports / output register / zero-fill) checked against a queue-based reference model.
module tb_std_block_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic [2:0]  v;
    logic [3:0]  we [3];
    logic [9:0]  ad [3];
    logic [31:0] dt [3];

    logic [1:0]  a_v, a_rdy, a_rv;
    logic [31:0] a_rdata, a_rdin, a_rdout;
    logic        a_idone, a_ren, a_reo;
    logic [3:0]  a_rwe;
    logic [9:0]  a_raddr;
    logic [2:0]  b_v, b_rdy, b_rv;
    logic [31:0] b_rdata, b_rdin, b_rdout, b_d1;
    logic        b_idone, b_ren, b_reo;
    logic [3:0]  b_rwe;
    logic [3:0]  b_raddr;
    logic [2:0]  rdy, rv;
    logic [31:0] rdata;
    logic        idone, reo;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [16];

    typedef struct {
        int          due;
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] shadow [16];
    int tests = 0, fails = 0, cyc = 0, np = 2, lat = 1, ptr_m = 0, init_left = 0, last_grant = -1;

    always #5 clk = ~clk;

    assign a_v = (sel == 0) ? v[1:0] : 2'b00;
    assign b_v = (sel == 1) ? v : 3'b000;

    std_block_ram_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .ADDR_WIDTH(10),
                            .ENABLE_OUTPUT_REG(0), .CLEAR_ON_RESET(0)) u_a (
        .clk(clk), .rst(rst), .i_req_valid(a_v), .o_req_ready(a_rdy),
        .i_req_write_enable({we[1], we[0]}), .i_req_addr({ad[1], ad[0]}),
        .i_req_data({dt[1], dt[0]}), .o_resp_valid(a_rv), .o_resp_data(a_rdata),
        .o_init_done(a_idone), .o_ram_enable(a_ren), .o_ram_enable_output(a_reo),
        .o_ram_write_enable(a_rwe), .o_ram_addr(a_raddr), .o_ram_data_in(a_rdin),
        .i_ram_data_out(a_rdout));

    std_block_ram_arbiter #(.NUM_PORTS(3), .DATA_WIDTH(32), .ADDR_WIDTH(4),
                            .ENABLE_OUTPUT_REG(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst), .i_req_valid(b_v), .o_req_ready(b_rdy),
        .i_req_write_enable({we[2], we[1], we[0]}),
        .i_req_addr({ad[2][3:0], ad[1][3:0], ad[0][3:0]}),
        .i_req_data({dt[2], dt[1], dt[0]}), .o_resp_valid(b_rv), .o_resp_data(b_rdata),
        .o_init_done(b_idone), .o_ram_enable(b_ren), .o_ram_enable_output(b_reo),
        .o_ram_write_enable(b_rwe), .o_ram_addr(b_raddr), .o_ram_data_in(b_rdin),
        .i_ram_data_out(b_rdout));

    assign rdy   = (sel == 0) ? {1'b0, a_rdy} : b_rdy;
    assign rv    = (sel == 0) ? {1'b0, a_rv} : b_rv;
    assign rdata = (sel == 0) ? a_rdata : b_rdata;
    assign idone = (sel == 0) ? a_idone : b_idone;
    assign reo   = (sel == 0) ? a_reo : b_reo;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        merge = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) merge[8*b +: 8] = nw[8*b +: 8];
        end
    endfunction

    // Read-first single-port RAMs; the second one has an output register.
    always @(posedge clk) begin
        if (a_ren) begin
            a_rdout <= mem_a[a_raddr];
            mem_a[a_raddr] <= merge(mem_a[a_raddr], a_rdin, a_rwe);
        end
        if (b_ren) begin
            b_d1 <= mem_b[b_raddr];
            mem_b[b_raddr] <= merge(mem_b[b_raddr], b_rdin, b_rwe);
        end
        if (b_reo) b_rdout <= b_d1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic tick();
        logic [2:0] erv;
        logic [2:0] erdy;
        exp_t       e;
        int         g;
        #1;
        if (rst) q.delete();
        erv = 3'b000;
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].port] = 1'b1;
            if (!$isunknown(q[0].data)) chk("resp_data", rdata, q[0].data);
            void'(q.pop_front());
        end
        chk("resp_valid", rv, erv);
        g = -1;
        if (!rst && init_left == 0) begin
            for (int k = 0; k < np; k++) begin
                int idx = (ptr_m + k) % np;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        erdy = 3'b000;
        if (g >= 0) erdy[g] = 1'b1;
        chk("req_ready", rdy, erdy);
        if (sel == 1 && !rst) chk("init_done", idone, init_left == 0);
        if (g >= 0) begin
            e.due  = cyc + lat;
            e.port = g;
            e.data = shadow[ad[g][3:0]];
            q.push_back(e);
            shadow[ad[g][3:0]] = merge(shadow[ad[g][3:0]], dt[g], we[g]);
            ptr_m = (g + 1) % np;
        end
        last_grant = g;
        if (rst) begin
            ptr_m = 0;
            init_left = (sel == 1) ? 16 : 0;
            if (sel == 1) for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
        end else if (init_left > 0) begin
            init_left--;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic spot(input string tag, input logic [2:0] erv, input logic [31:0] ed,
                        input bit dchk);
        #1;
        chk(tag, rv, erv);
        if (dchk) chk(tag, rdata, ed);
    endtask

    task automatic issue(input int p, input logic [3:0] m, input logic [9:0] a,
                         input logic [31:0] d);
        int n = 0;
        v[p] = 1'b1; we[p] = m; ad[p] = a; dt[p] = d;
        do begin
            tick();
            n++;
        end while (last_grant != p && n < 40);
        chk("issue_accept", last_grant, p);
        v[p] = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int p = 0; p < np; p++) begin
                if (!v[p] && $urandom_range(0, 3) != 0) begin
                    we[p] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                    ad[p] = 10'($urandom_range(0, 15));
                    dt[p] = $urandom;
                    v[p]  = 1'b1;
                end
            end
            tick();
            if (last_grant >= 0) v[last_grant] = 1'b0;
        end
        v = 3'b000;
        for (int c = 0; c < 4; c++) tick();
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; rst = 1'b1; v = 3'b000;
        for (int p = 0; p < 3; p++) begin we[p] = 4'h0; ad[p] = 10'd0; dt[p] = 32'h0; end
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("ram_eo_a", reo, 1'b1);

        issue(0, 4'hF, 10'd5, 32'hDEADBEEF);
        issue(0, 4'h0, 10'd5, 32'h0);
        spot("rd5", 3'b001, 32'hDEADBEEF, 1'b1);
        issue(0, 4'hF, 10'd5, 32'h11111111);
        spot("read_first", 3'b001, 32'hDEADBEEF, 1'b1);
        issue(0, 4'hF, 10'd3, 32'hAABBCCDD);
        issue(0, 4'b0001, 10'd3, 32'h00000011);
        issue(0, 4'h0, 10'd3, 32'h0);
        spot("byte_mask", 3'b001, 32'hAABBCC11, 1'b1);

        rst = 1'b1; tick(); rst = 1'b0; tick();
        ad[0] = 10'd5; ad[1] = 10'd5; we[0] = 4'h0; we[1] = 4'h0;
        v = 3'b011;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) spot("rr_resp", 3'b001 << ((k - 1) % 2), 32'h0, 1'b0);
            tick();
            chk("rr_grant", last_grant, k % 2);
        end
        v = 3'b000;
        spot("rr_resp_last", 3'b010, 32'h0, 1'b0);
        tick();

        issue(1, 4'h0, 10'd5, 32'h0);
        rst = 1'b1;
        spot("rst_drop", 3'b000, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        spot("post_rst", 3'b000, 32'h0, 1'b0);
        v = 3'b011;
        tick();
        chk("rst_ptr", last_grant, 0);
        v = 3'b000;
        tick();

        for (int a = 0; a < 16; a++) issue(0, 4'hF, 10'(a), $urandom);
        run_random(300);

        sel = 1; np = 3; lat = 2; q.delete();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("ram_eo_b", reo, 1'b1);
        v[0] = 1'b1; we[0] = 4'h0; ad[0] = 10'd1;
        for (int c = 0; c < 16; c++) tick();
        #1;
        chk("init_done_rise", idone, 1'b1);
        tick();
        chk("first_after_init", last_grant, 0);
        v = 3'b000;

        for (int a = 0; a < 4; a++) issue(2, 4'hF, 10'(a), 32'h1000 + 32'(a) + 32'h1);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 16; c++) tick();
        issue(1, 4'h0, 10'd2, 32'h0);
        tick();
        spot("clear_rd", 3'b010, 32'h0, 1'b1);

        issue(0, 4'hF, 10'd0, 32'hA0A00000);
        issue(1, 4'hF, 10'd1, 32'hA0A00001);
        issue(2, 4'hF, 10'd2, 32'hA0A00002);
        v[0] = 1'b1; we[0] = 4'h0; ad[0] = 10'd0;
        tick();
        chk("b2b_grant0", last_grant, 0);
        ad[0] = 10'd1;
        tick();
        chk("b2b_grant1", last_grant, 0);
        spot("b2b_rd0", 3'b001, 32'hA0A00000, 1'b1);
        ad[0] = 10'd2;
        tick();
        chk("b2b_grant2", last_grant, 0);
        v = 3'b000;
        spot("b2b_rd1", 3'b001, 32'hA0A00001, 1'b1);
        tick();
        spot("b2b_rd2", 3'b001, 32'hA0A00002, 1'b1);
        tick();

        run_random(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
